// File: rtl/data_memory_mc.sv
// data_memory_mc: multi-cycle data memory with a fixed request-to-response
// latency. It takes one request at a time and answers each load or store
// with a single-cycle response pulse.
//
// Parameters:
//   MEM_DEPTH - number of 32-bit words (power of two, >= 4)
//   LATENCY   - cycles from request acceptance to response (>= 1)
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset; also clears the memory
//   req_valid    - request present
//   req_ready    - high only in IDLE; a request is taken when valid & ready
//   req_write    - 1 = store, 0 = load
//   req_addr     - byte address (word index wraps modulo MEM_DEPTH)
//   req_wdata    - store data, right-aligned
//   req_size     - 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned - 1 = zero-extend loads, 0 = sign-extend loads
//   resp_valid   - one-cycle completion pulse
//   resp_rdata   - extended load data (0 for stores and outside the pulse)
//   resp_err     - alignment fault, qualified by resp_valid
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned half/word
// accesses and the reserved size. Without it resp_err is always 0, the low
// address bits are ignored for halves/words, and size 11 behaves as a word.
module data_memory_mc #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept, enter_resp;

  logic [31:0] mem [MEM_DEPTH];

  logic          write_q, uns_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          s_write, s_uns;
  logic [1:0]    s_size;
  logic [AW+1:0] s_addr;
  logic [31:0]   s_wdata;

  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlanes, word, load_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          fault;

  logic resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  // Address bits above the memory's index range wrap away silently.
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addr[31:AW+2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The counter is loaded with LATENCY-1 on accept and counts down in WAIT;
  // the edge on which it reaches zero is the edge that enters RESP, so the
  // response lands in the LATENCY-th cycle after the accepting edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
            cnt_n      = '0;
          end else begin
            state_n = WAIT;
            cnt_n   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  // With LATENCY = 1 the response is produced on the accepting edge itself,
  // before the latched copy exists, so IDLE uses the live request fields.
  always_comb begin
    if (state == IDLE) begin
      s_write = req_write;
      s_uns   = req_unsigned;
      s_size  = req_size;
      s_addr  = req_addr[AW+1:0];
      s_wdata = req_wdata;
    end else begin
      s_write = write_q;
      s_uns   = uns_q;
      s_size  = size_q;
      s_addr  = addr_q;
      s_wdata = wdata_q;
    end
  end

  // Little-endian lane steering for stores and lane extraction for loads.
  always_comb begin
    off       = s_addr[1:0];
    idx       = s_addr[AW+1:2];
    word      = mem[idx];
    be        = 4'b1111;
    wlanes    = s_wdata;
    byte_v    = word[{off, 3'b000} +: 8];
    half_v    = off[1] ? word[31:16] : word[15:0];
    load_data = word;
    fault     = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    fault = ((s_size == 2'b01) && off[0]) ||
            ((s_size == 2'b10) && (off != 2'b00)) ||
            (s_size == 2'b11);
`endif
    case (s_size)
      2'b00: begin
        be        = 4'b0001 << off;
        wlanes    = {4{s_wdata[7:0]}};
        load_data = {{24{~s_uns & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wlanes    = {2{s_wdata[15:0]}};
        load_data = {{16{~s_uns & half_v[15]}}, half_v};
      end
      default: begin
        be        = 4'b1111;
        wlanes    = s_wdata;
        load_data = word;
      end
    endcase
    if (fault || !s_write) be = 4'b0000;
    if (fault || s_write) load_data = '0;
  end

  // Reset wipes the whole array; an access in flight is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

  // Response registers are written only on the edge entering RESP and cleared
  // on every other edge, which keeps data and error at 0 outside the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= enter_resp;
      resp_rdata_q <= enter_resp ? load_data : '0;
      resp_err_q   <= enter_resp & fault;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_mc.sv
// tb_data_memory_mc: directed bench for data_memory_mc. Three instances cover
// the configurations of interest:
//   u0 - MEM_DEPTH 16384, LATENCY 2 (main load/store lane behaviour)
//   u1 - MEM_DEPTH 16,    LATENCY 1 (address wrap, single-cycle latency)
//   u2 - MEM_DEPTH 64,    LATENCY 4 (reset abort in the middle of WAIT)
// Expected results follow DMEM_ALIGN_CHECK_EN when it is defined.
module tb_data_memory_mc;

  logic clk;
  logic        rst  [3];
  logic        rv   [3];
  logic        rw   [3];
  logic        ru   [3];
  logic [1:0]  rs   [3];
  logic [31:0] ra   [3];
  logic [31:0] rwd  [3];
  logic        rdy  [3];
  logic        vv   [3];
  logic [31:0] rd   [3];
  logic        er   [3];

  int lat_of [3] = '{2, 1, 4};

  int vectors = 0;
  int miscompares = 0;

  data_memory_mc #(.MEM_DEPTH(16384), .LATENCY(2)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .req_size(rs[0]),
    .req_unsigned(ru[0]), .resp_valid(vv[0]), .resp_rdata(rd[0]), .resp_err(er[0])
  );

  data_memory_mc #(.MEM_DEPTH(16), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .req_size(rs[1]),
    .req_unsigned(ru[1]), .resp_valid(vv[1]), .resp_rdata(rd[1]), .resp_err(er[1])
  );

  data_memory_mc #(.MEM_DEPTH(64), .LATENCY(4)) u2 (
    .clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_write(rw[2]), .req_addr(ra[2]), .req_wdata(rwd[2]), .req_size(rs[2]),
    .req_unsigned(ru[2]), .resp_valid(vv[2]), .resp_rdata(rd[2]), .resp_err(er[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance s: wait for ready, present the request
  // for exactly one accepting edge, then watch LATENCY+1 cycles for the
  // response pulse, the ready pattern, and quiet outputs outside the pulse.
  task automatic applyStimulus(input int s, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wd,
                               output logic [31:0] rdata, output logic err);
    int lat;
    int seen;
    int pulses;
    int w;
    logic ready_ok;
    logic quiet_ok;
    lat = lat_of[s];
    seen = 0;
    pulses = 0;
    w = 0;
    ready_ok = 1'b1;
    quiet_ok = 1'b1;
    rdata = '0;
    err = 1'b0;
    @(negedge clk);
    while (!rdy[s] && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready_wait", 32'(rdy[s]), 32'd1);
    rv[s]  = 1'b1;
    rw[s]  = wr;
    rs[s]  = sz;
    ru[s]  = uns;
    ra[s]  = addr;
    rwd[s] = wd;
    @(posedge clk);
    #1 rv[s] = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (vv[s]) begin
        pulses++;
        seen = k;
        rdata = rd[s];
        err = er[s];
      end else if (rd[s] != 32'd0 || er[s]) begin
        quiet_ok = 1'b0;
      end
      if (k <= lat && rdy[s]) ready_ok = 1'b0;
      if (k == lat + 1 && !rdy[s]) ready_ok = 1'b0;
    end
    checkOutput("resp_cycle", 32'(seen), 32'(lat));
    checkOutput("resp_pulses", 32'(pulses), 32'd1);
    checkOutput("ready_seq", 32'(ready_ok), 32'd1);
    checkOutput("quiet_zero", 32'(quiet_ok), 32'd1);
  endtask

  task automatic do_store(input int s, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic err;
    applyStimulus(s, 1'b1, sz, 1'b0, addr, wd, rdata, err);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic do_load(input int s, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp,
                         input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic err;
    applyStimulus(s, 1'b0, sz, uns, addr, 32'd0, rdata, err);
    checkOutput(tag, rdata, exp);
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  initial begin
    int pulses;
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1;
      rv[s]  = 1'b0;
      rw[s]  = 1'b0;
      ru[s]  = 1'b0;
      rs[s]  = SZ_W;
      ra[s]  = '0;
      rwd[s] = '0;
    end
    // A store presented during reset must be ignored.
    rv[0] = 1'b1;
    rw[0] = 1'b1;
    ra[0] = 32'h200;
    rwd[0] = 32'hAAAAAAAA;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) rst[s] = 1'b0;
    rv[0] = 1'b0;
    rw[0] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checkOutput("rst_ready", 32'(rdy[s]), 32'd1);
      checkOutput("rst_valid", 32'(vv[s]), 32'd0);
      checkOutput("rst_rdata", rd[s], 32'd0);
      checkOutput("rst_err", 32'(er[s]), 32'd0);
    end

    do_load(0, SZ_W, 1'b0, 32'h200, 32'h0, 1'b0, "lw_ignored_in_reset");

    // Word store/load round trip.
    do_store(0, SZ_W, 32'h100, 32'hDEADBEEF, 1'b0, "sw_deadbeef");
    do_load (0, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, "lw_deadbeef");

    // Byte lanes and extension.
    do_store(0, SZ_W, 32'h100, 32'h11223344, 1'b0, "sw_base_b");
    do_store(0, SZ_B, 32'h103, 32'h00000080, 1'b0, "sb_80");
    do_load (0, SZ_B, 1'b0, 32'h103, 32'hFFFFFF80, 1'b0, "lb_103");
    do_load (0, SZ_B, 1'b1, 32'h103, 32'h00000080, 1'b0, "lbu_103");
    do_load (0, SZ_W, 1'b0, 32'h100, 32'h80223344, 1'b0, "lw_after_sb");
    do_store(0, SZ_B, 32'h201, 32'h0000017F, 1'b0, "sb_7f");
    do_load (0, SZ_B, 1'b0, 32'h201, 32'h0000007F, 1'b0, "lb_201");
    do_load (0, SZ_W, 1'b0, 32'h200, 32'h00007F00, 1'b0, "lw_after_sb7f");

    // Half lanes and extension.
    do_store(0, SZ_W, 32'h100, 32'h11223344, 1'b0, "sw_base_h");
    do_store(0, SZ_H, 32'h102, 32'h0000BEEF, 1'b0, "sh_beef");
    do_load (0, SZ_H, 1'b0, 32'h102, 32'hFFFFBEEF, 1'b0, "lh_102");
    do_load (0, SZ_H, 1'b1, 32'h102, 32'h0000BEEF, 1'b0, "lhu_102");
    do_load (0, SZ_W, 1'b0, 32'h100, 32'hBEEF3344, 1'b0, "lw_after_sh");
    do_load (0, SZ_H, 1'b0, 32'h100, 32'h00003344, 1'b0, "lh_100");
    do_load (0, SZ_W, 1'b1, 32'h100, 32'hBEEF3344, 1'b0, "lw_unsigned");

`ifdef DMEM_ALIGN_CHECK_EN
    do_load (0, SZ_W, 1'b0, 32'h101, 32'h0, 1'b1, "lw_mis_101");
    do_store(0, SZ_W, 32'h102, 32'h00000055, 1'b1, "sw_mis_102");
    do_load (0, SZ_W, 1'b0, 32'h100, 32'hBEEF3344, 1'b0, "lw_unchanged");
    do_load (0, SZ_H, 1'b0, 32'h101, 32'h0, 1'b1, "lh_mis_101");
    do_load (0, SZ_R, 1'b0, 32'h100, 32'h0, 1'b1, "lr_reserved");
`else
    do_load (0, SZ_W, 1'b0, 32'h101, 32'hBEEF3344, 1'b0, "lw_mis_101");
    do_load (0, SZ_H, 1'b1, 32'h103, 32'h0000BEEF, 1'b0, "lhu_mis_103");
    do_load (0, SZ_R, 1'b0, 32'h100, 32'hBEEF3344, 1'b0, "lr_as_word");
    do_store(0, SZ_W, 32'h102, 32'h00000055, 1'b0, "sw_mis_102");
    do_load (0, SZ_W, 1'b0, 32'h100, 32'h00000055, 1'b0, "lw_after_mis_sw");
`endif

    // Address wrap with a 16-word memory and single-cycle latency.
    do_store(1, SZ_W, 32'h40, 32'hCAFEF00D, 1'b0, "sw_wrap");
    do_load (1, SZ_W, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "lw_wrap");
    do_store(1, SZ_H, 32'h3E, 32'h00001234, 1'b0, "sh_top");
    do_load (1, SZ_H, 1'b1, 32'h3E, 32'h00001234, 1'b0, "lhu_top");
    do_load (1, SZ_W, 1'b0, 32'h7C, 32'h12340000, 1'b0, "lw_top_wrap");

    // Reset during the second WAIT cycle aborts the store.
    @(negedge clk);
    rv[2]  = 1'b1;
    rw[2]  = 1'b1;
    rs[2]  = SZ_W;
    ru[2]  = 1'b0;
    ra[2]  = 32'h0;
    rwd[2] = 32'h12345678;
    checkOutput("abort_pre_ready", 32'(rdy[2]), 32'd1);
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(posedge clk);
    #1 rst[2] = 1'b1;
    @(posedge clk);
    #1 rst[2] = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("abort_ready", 32'(rdy[2]), 32'd1);
      if (vv[2]) pulses++;
    end
    checkOutput("abort_pulses", 32'(pulses), 32'd0);
    do_load (2, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0, "lw_after_abort");
    do_store(2, SZ_W, 32'h8, 32'hA5A5A5A5, 1'b0, "sw_l4");
    do_load (2, SZ_W, 1'b0, 32'h8, 32'hA5A5A5A5, 1'b0, "lw_l4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_mc.md
DATA_MEMORY_MC -- requirements
Module: data_memory_mc

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16384, meaning number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response; minimum 1.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-011 SHALL have port req_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse, for loads and stores.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  access faulted; qualified by resp_valid.

Function
REQ-015 SHALL implement states IDLE, WAIT and RESP, and SHALL drive req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on an edge where req_valid and req_ready are both 1: latch all req_* fields, load the counter with LATENCY-1, and go to WAIT (or to RESP directly when LATENCY = 1).
REQ-017 SHALL decrement the counter each edge in WAIT and go to RESP on the edge where the counter is 0.
REQ-018 SHALL perform the memory write and sample the read data on the edge that enters RESP, so that resp_valid is high exactly in the LATENCY-th cycle after the accepting edge.
REQ-019 SHALL return from RESP to IDLE unconditionally after one cycle; there is no response back-pressure, and the sustained rate is one request per LATENCY+1 cycles.
REQ-020 SHALL ignore req_valid outside IDLE and SHALL not queue requests.
REQ-021 SHALL compute the word index as req_addr[31:2] modulo MEM_DEPTH, so addresses wrap silently.
REQ-022 SHALL use little-endian byte lanes:
- byte: lane addr[1:0]
- half: lanes {addr[1],1} and {addr[1],0}
- word: all four lanes
REQ-023 SHALL leave unaddressed lanes unchanged on every store.
REQ-024 SHALL extract the addressed byte or half on loads and extend it per req_unsigned; word loads ignore req_unsigned.
REQ-025 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid is 0.

Reset
REQ-026 SHALL, while reset is 1 at an edge: clear every memory word to 0, force state IDLE and counter 0, and drive resp_valid, resp_rdata and resp_err to 0.
REQ-027 SHALL treat reset during WAIT or RESP as an abort: no write is performed and no resp_valid pulse follows.
REQ-028 SHALL ignore requests presented while reset is 1; req_ready is 1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL gate alignment checking with macro DMEM_ALIGN_CHECK_EN.
REQ-030 SHALL, with DMEM_ALIGN_CHECK_EN defined, flag resp_err = 1 on any of:
- half access with addr[0] = 1
- word access with addr[1:0] != 00
- req_size = 11
A faulting access performs no write and returns resp_rdata = 0, with the same latency as a normal access.
REQ-031 SHALL, without DMEM_ALIGN_CHECK_EN, tie resp_err to 0, ignore addr[0] for halves and addr[1:0] for words, and treat req_size = 11 as word.

Verification
REQ-032 SHALL pass (LATENCY=2): sw 0xDEADBEEF @0x100 then lw @0x100 -> resp_valid exactly 2 cycles after each accept, resp_rdata 0xDEADBEEF, req_ready 0 from accept until return to IDLE.
REQ-033 SHALL pass: sw 0x11223344 @0x100, sb 0x80 @0x103 -> lb @0x103 returns 0xFFFFFF80, lbu @0x103 returns 0x00000080, lw @0x100 returns 0x80223344.
REQ-034 SHALL pass: sh 0xBEEF @0x102 over 0x11223344 -> lh @0x102 returns 0xFFFFBEEF, lhu @0x102 returns 0x0000BEEF, lw @0x100 returns 0xBEEF3344.
REQ-035 SHALL pass (MEM_DEPTH=16, LATENCY=1): sw 0xCAFEF00D @0x40 -> lw @0x0 returns 0xCAFEF00D one cycle after accept.
REQ-036 SHALL pass with DMEM_ALIGN_CHECK_EN: lw @0x101 -> resp_err 1, rdata 0; sw 0x55 @0x102 -> resp_err 1, lw @0x100 unchanged. Without the macro, lw @0x101 returns the word at 0x100 and resp_err is 0.
REQ-037 SHALL pass (LATENCY=4): reset asserted in the 2nd WAIT cycle -> no resp_valid, req_ready 1 in the first cycle after release, lw @0x0 returns 0.
